// File: rtl/lsu_dbus.sv
// rtl/lsu_dbus.sv - LSU data-bus master, one request at a time, registered response.
// Define LSU_MISALIGN_EN to split misaligned accesses into two bus transactions.
module lsu_dbus #(
    parameter int TagW = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            lsu_req_i,
    input  logic [31:0]     lsu_addr_i,
    input  logic            lsu_we_i,
    input  logic [1:0]      lsu_size_i,
    input  logic            lsu_sext_i,
    input  logic [31:0]     lsu_wdata_i,
    input  logic [TagW-1:0] lsu_tag_i,
    output logic            lsu_req_done_o,
    output logic            data_req_o,
    input  logic            data_gnt_i,
    output logic [31:0]     data_addr_o,
    output logic            data_we_o,
    output logic [3:0]      data_be_o,
    output logic [31:0]     data_wdata_o,
    input  logic            data_rvalid_i,
    input  logic [31:0]     data_rdata_i,
    input  logic            data_err_i,
    output logic            resp_valid_o,
    output logic [31:0]     resp_rdata_o,
    output logic            resp_err_o,
    output logic            resp_misalign_o,
    output logic [TagW-1:0] resp_tag_o
);

`ifdef LSU_MISALIGN_EN
    typedef enum logic [1:0] {IDLE, WAIT0, ISSUE1, WAIT1} state_e;
`else
    typedef enum logic [1:0] {IDLE, WAIT0} state_e;
`endif

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic sext);
        case (size)
            2'd0:    return {{24{sext & raw[7]}}, raw[7:0]};
            2'd1:    return {{16{sext & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    state_e          state_q, state_d;
    logic [1:0]      off_q, size_q;
    logic            we_q, sext_q;
    logic [TagW-1:0] tag_q;

    logic            capture;
    logic            resp_fire, resp_err_d, resp_mis_d;
    logic [31:0]     resp_rdata_d;
    logic [TagW-1:0] resp_tag_d;

    logic [1:0]      in_off;
    logic            in_mis, mis_reject;
    logic [3:0]      be0;
    logic [31:0]     wdata0, rd_part0;

    assign in_off   = lsu_addr_i[1:0];
    assign in_mis   = (lsu_size_i == 2'd1 && in_off == 2'd3) || (lsu_size_i[1] && in_off != 2'd0);
    assign be0      = size_mask(lsu_size_i) << in_off;
    assign wdata0   = lsu_wdata_i << {in_off, 3'b000};
    assign rd_part0 = data_rdata_i >> {off_q, 3'b000};

`ifdef LSU_MISALIGN_EN
    logic [31:2] waddr_q;
    logic [31:0] wdata_q, rdata_q;
    logic        mis_q;
    logic [2:0]  inv_off;
    logic [3:0]  be1;
    logic [31:0] wdata1, rd_merged;

    assign mis_reject = 1'b0;
    assign inv_off    = 3'd4 - {1'b0, off_q};
    assign be1        = size_mask(size_q) >> inv_off;
    assign wdata1     = wdata_q >> {inv_off, 3'b000};
    assign rd_merged  = rdata_q | (data_rdata_i << {inv_off, 3'b000});

    // Part-1 context; the part-0 bytes wait here until the second beat arrives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            waddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            if (capture) begin
                waddr_q <= lsu_addr_i[31:2];
                wdata_q <= lsu_wdata_i;
                mis_q   <= in_mis;
            end
            if (state_q == WAIT0 && data_rvalid_i) rdata_q <= rd_part0;
        end
    end
`else
    assign mis_reject = in_mis;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        lsu_req_done_o = 1'b0;
        data_req_o     = 1'b0;
        data_addr_o    = '0;
        data_we_o      = 1'b0;
        data_be_o      = '0;
        data_wdata_o   = '0;
        capture        = 1'b0;
        resp_fire      = 1'b0;
        resp_rdata_d   = '0;
        resp_err_d     = 1'b0;
        resp_mis_d     = 1'b0;
        resp_tag_d     = tag_q;
        case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    if (mis_reject) begin
                        // Unsplittable access: retire it without touching the bus.
                        lsu_req_done_o = 1'b1;
                        resp_fire      = 1'b1;
                        resp_err_d     = 1'b1;
                        resp_mis_d     = 1'b1;
                        resp_tag_d     = lsu_tag_i;
                    end else begin
                        data_req_o   = 1'b1;
                        data_addr_o  = {lsu_addr_i[31:2], 2'b00};
                        data_we_o    = lsu_we_i;
                        data_be_o    = be0;
                        data_wdata_o = wdata0;
                        if (data_gnt_i) begin
                            lsu_req_done_o = 1'b1;
                            capture        = 1'b1;
                            state_d        = WAIT0;
                        end
                    end
                end
            end
            WAIT0: begin
                if (data_rvalid_i) begin
                    resp_fire    = 1'b1;
                    resp_err_d   = data_err_i;
                    resp_rdata_d = we_q ? '0 : extend(rd_part0, size_q, sext_q);
                    state_d      = IDLE;
`ifdef LSU_MISALIGN_EN
                    if (mis_q && !data_err_i) begin
                        resp_fire = 1'b0;
                        state_d   = ISSUE1;
                    end
`endif
                end
            end
`ifdef LSU_MISALIGN_EN
            ISSUE1: begin
                data_req_o   = 1'b1;
                data_addr_o  = {waddr_q + 30'd1, 2'b00};
                data_we_o    = we_q;
                data_be_o    = be1;
                data_wdata_o = wdata1;
                if (data_gnt_i) state_d = WAIT1;
            end
            WAIT1: begin
                if (data_rvalid_i) begin
                    resp_fire    = 1'b1;
                    resp_err_d   = data_err_i;
                    resp_rdata_d = we_q ? '0 : extend(rd_merged, size_q, sext_q);
                    state_d      = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            off_q  <= '0;
            size_q <= '0;
            we_q   <= 1'b0;
            sext_q <= 1'b0;
            tag_q  <= '0;
        end else if (capture) begin
            off_q  <= in_off;
            size_q <= lsu_size_i;
            we_q   <= lsu_we_i;
            sext_q <= lsu_sext_i;
            tag_q  <= lsu_tag_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_o    <= 1'b0;
            resp_rdata_o    <= '0;
            resp_err_o      <= 1'b0;
            resp_misalign_o <= 1'b0;
            resp_tag_o      <= '0;
        end else begin
            resp_valid_o <= resp_fire;
            if (resp_fire) begin
                resp_rdata_o    <= resp_rdata_d;
                resp_err_o      <= resp_err_d;
                resp_misalign_o <= resp_mis_d;
                resp_tag_o      <= resp_tag_d;
            end
        end
    end

endmodule

// File: tb/tb_lsu_dbus.sv
// tb/tb_lsu_dbus.sv - lsu_dbus bench: byte-lane reference model, random bus responder.
module tb_lsu_dbus;
    localparam int TagW = 5;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            lsu_req_i = 1'b0;
    logic [31:0]     lsu_addr_i = '0;
    logic            lsu_we_i = 1'b0;
    logic [1:0]      lsu_size_i = '0;
    logic            lsu_sext_i = 1'b0;
    logic [31:0]     lsu_wdata_i = '0;
    logic [TagW-1:0] lsu_tag_i = '0;
    logic            lsu_req_done_o;
    logic            data_req_o;
    logic            data_gnt_i;
    logic [31:0]     data_addr_o;
    logic            data_we_o;
    logic [3:0]      data_be_o;
    logic [31:0]     data_wdata_o;
    logic            data_rvalid_i;
    logic [31:0]     data_rdata_i;
    logic            data_err_i;
    logic            resp_valid_o;
    logic [31:0]     resp_rdata_o;
    logic            resp_err_o;
    logic            resp_misalign_o;
    logic [TagW-1:0] resp_tag_o;

    always #5 clk = ~clk;

    lsu_dbus #(.TagW(TagW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_we_i(lsu_we_i),
        .lsu_size_i(lsu_size_i), .lsu_sext_i(lsu_sext_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_tag_i(lsu_tag_i), .lsu_req_done_o(lsu_req_done_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .resp_misalign_o(resp_misalign_o), .resp_tag_o(resp_tag_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic        last;
    } part_t;

    typedef struct packed {
        logic [31:0]     rdata;
        logic            err;
        logic            mis;
        logic [TagW-1:0] tag;
    } resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          cyc;
    } log_t;

    part_t exp_bus[$];
    resp_t exp_resp[$];
    int    resp_cycles[$];
    log_t  log_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int gnt_mode = 0;      // 0 random, 1 always, 2 held low
    bit fast = 1'b0;
    bit rv_hold = 1'b0;
    int resp_count = 0;
    logic [31:0]     last_rdata;
    logic            last_err, last_mis;
    logic [TagW-1:0] last_tag;
    int              last_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus slave: random grants, rvalid 1..3 cycles after the grant cycle.
    initial begin
        bit    acc;
        bit    pend;
        int    wt;
        part_t cur;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;
        pend = 1'b0; wt = 0; cur = '0;
        forever begin
            @(negedge clk);
            acc = data_req_o && data_gnt_i && rst_ni;
            @(posedge clk);
            #1;
            data_rvalid_i = 1'b0;
            data_err_i    = 1'b0;
            data_rdata_i  = $urandom;
            case (gnt_mode)
                0:       data_gnt_i = 1'($urandom_range(0, 1));
                1:       data_gnt_i = 1'b1;
                default: data_gnt_i = 1'b0;
            endcase
            if (!rst_ni) begin
                pend = 1'b0;
            end else begin
                if (acc) begin
                    if (exp_bus.size() > 0) cur = exp_bus.pop_front();
                    pend = 1'b1;
                    wt   = fast ? 0 : $urandom_range(0, 2);
                end
                if (pend && !rv_hold) begin
                    if (wt == 0) begin
                        data_rvalid_i = 1'b1;
                        data_rdata_i  = cur.rdata;
                        data_err_i    = cur.err;
                        pend          = 1'b0;
                        if (cur.last) resp_cycles.push_back(cyc + 1);
                    end else begin
                        wt--;
                    end
                end
            end
        end
    end

    // Single compare process against the model queues.
    initial begin
        bit    exp_v;
        resp_t r;
        part_t p;
        log_t  l;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                exp_v = (resp_cycles.size() > 0) && (resp_cycles[0] == cyc);
                if (exp_v) void'(resp_cycles.pop_front());
                check("resp_valid", resp_valid_o, exp_v);
                if (resp_valid_o) begin
                    if (exp_resp.size() == 0) begin
                        check("resp_unexpected", 1, 0);
                    end else begin
                        r = exp_resp.pop_front();
                        check("resp_tag", resp_tag_o, r.tag);
                        check("resp_err", resp_err_o, r.err);
                        check("resp_misalign", resp_misalign_o, r.mis);
                        if (!r.err || r.mis) check("resp_rdata", resp_rdata_o, r.rdata);
                    end
                    resp_count++;
                    last_rdata = resp_rdata_o; last_err = resp_err_o;
                    last_mis = resp_misalign_o; last_tag = resp_tag_o; last_cyc = cyc;
                end
                if (data_req_o) begin
                    if (exp_bus.size() == 0) begin
                        check("bus_unexpected", 1, 0);
                    end else begin
                        p = exp_bus[0];
                        check("bus_addr", data_addr_o, p.addr);
                        check("bus_be", data_be_o, p.be);
                        check("bus_we", data_we_o, p.we);
                        check("bus_wdata", data_wdata_o, p.wdata);
                    end
                    if (data_gnt_i) begin
                        l.addr = data_addr_o; l.be = data_be_o; l.wdata = data_wdata_o; l.cyc = cyc;
                        log_q.push_back(l);
                    end
                end else if (!lsu_req_i && exp_bus.size() == 0 && exp_resp.size() == 0) begin
                    check("idle_bus", {data_addr_o[31:1] | data_wdata_o[31:1],
                                       data_addr_o[0] | data_wdata_o[0] | data_we_o | (|data_be_o)}, 0);
                end
            end
        end
    end

    // Byte-lane reference: which lane each request byte lands on, and in which beat.
    task automatic send(input logic [31:0] addr, input logic [1:0] size, input logic we,
                        input logic sext, input logic [31:0] wdata, input logic [TagW-1:0] tag,
                        input logic [31:0] rd0, input logic [31:0] rd1,
                        input logic e0, input logic e1, output int dc);
        int          off, n, lane, k;
        bit          mis, reject, got;
        part_t       p0, p1;
        resp_t       r;
        logic [31:0] val;
        off = int'(addr[1:0]);
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis = (off + n) > 4;
`ifdef LSU_MISALIGN_EN
        reject = 1'b0;
`else
        reject = mis;
`endif
        p0 = '0; p1 = '0; val = '0;
        p0.addr  = addr & 32'hFFFF_FFFC;
        p1.addr  = (addr & 32'hFFFF_FFFC) + 32'd4;
        p0.we    = we;   p1.we = we;
        p0.wdata = wdata << (8 * off);
        p1.wdata = wdata >> (8 * (4 - off));
        p0.rdata = rd0;  p1.rdata = rd1;
        p0.err   = e0;   p1.err = e1;
        for (int i = 0; i < n; i++) begin
            lane = off + i;
            if (lane < 4) begin
                p0.be[lane] = 1'b1;
                val[8*i +: 8] = rd0[8*lane +: 8];
            end else begin
                p1.be[lane-4] = 1'b1;
                val[8*i +: 8] = rd1[8*(lane-4) +: 8];
            end
        end
        if (n < 4 && sext && val[8*n-1]) val = val | ~((32'h1 << (8 * n)) - 32'h1);
        r.tag = tag;
        if (reject) begin
            r.rdata = '0; r.err = 1'b1; r.mis = 1'b1;
        end else begin
            p0.last = !(mis && !e0);
            exp_bus.push_back(p0);
            if (mis && !e0) begin
                p1.last = 1'b1;
                exp_bus.push_back(p1);
            end
            r.err   = e0 | (mis & e1);
            r.mis   = 1'b0;
            r.rdata = we ? 32'h0 : val;
        end
        exp_resp.push_back(r);
        lsu_addr_i = addr; lsu_size_i = size; lsu_we_i = we; lsu_sext_i = sext;
        lsu_wdata_i = wdata; lsu_tag_i = tag; lsu_req_i = 1'b1;
        got = 1'b0; k = 0; dc = -1;
        while (!got && k < 300) begin
            @(negedge clk);
            if (lsu_req_done_o) begin
                got = 1'b1;
                dc  = cyc;
            end
            k++;
        end
        check("req_done", got, 1);
        if (got && reject) resp_cycles.push_back(dc + 1);
        @(posedge clk);
        #1;
        lsu_req_i = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_resp.size() != 0 || resp_cycles.size() != 0) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("drain", (exp_resp.size() == 0 && resp_cycles.size() == 0), 1);
        @(posedge clk);
        #1;
        log_q.delete();
    endtask

    task automatic set_mode(input int g, input bit f);
        gnt_mode = g;
        fast     = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          dc, base;
        logic [31:0] a;
        repeat (2) begin
            @(negedge clk);
            check("rst_resp_valid", resp_valid_o, 0);
            check("rst_resp_err", {resp_err_o, resp_misalign_o}, 0);
            check("rst_resp_rdata", resp_rdata_o, 0);
            check("rst_resp_tag", resp_tag_o, 0);
            check("rst_data_req", data_req_o, 0);
            check("rst_bus_fields", {data_be_o, data_we_o}, 0);
            check("rst_bus_addr", data_addr_o, 0);
        end
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        set_mode(1, 1'b1);

        send(32'h100, 2'd2, 1'b0, 1'b0, 32'h0, 5'd1, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, dc);
        check("al_log_addr", log_q[0].addr, 32'h100);
        check("al_log_be", log_q[0].be, 4'b1111);
        drain();
        check("al_rdata", last_rdata, 32'hDEADBEEF);
        check("al_err", last_err, 0);
        check("al_latency", last_cyc, dc + 2);

        send(32'h103, 2'd0, 1'b0, 1'b1, 32'h0, 5'd2, 32'h80FFFFFF, 32'h0, 1'b0, 1'b0, dc);
        check("sb_be", log_q[0].be, 4'b1000);
        drain();
        check("sb_rdata", last_rdata, 32'hFFFFFF80);

`ifdef LSU_MISALIGN_EN
        base = resp_count;
        send(32'h102, 2'd2, 1'b1, 1'b0, 32'h11223344, 5'd3, 32'h0, 32'h0, 1'b0, 1'b0, dc);
        drain();
        check("ms_nparts", log_q.size(), 0);
        check("ms_nresp", resp_count - base, 1);
        check("ms_latency", last_cyc, dc + 4);
        send(32'h102, 2'd2, 1'b1, 1'b0, 32'h11223344, 5'd3, 32'h0, 32'h0, 1'b0, 1'b0, dc);
        repeat (3) @(negedge clk);
        check("ms_p0_addr", log_q[0].addr, 32'h100);
        check("ms_p0_be", log_q[0].be, 4'b1100);
        check("ms_p0_wdata", log_q[0].wdata, 32'h33440000);
        check("ms_p1_addr", log_q[1].addr, 32'h104);
        check("ms_p1_be", log_q[1].be, 4'b0011);
        check("ms_p1_wdata", log_q[1].wdata, 32'h00001122);
        check("ms_p1_cycle", log_q[1].cyc, log_q[0].cyc + 2);
        drain();

        send(32'hFFFFFFFF, 2'd1, 1'b0, 1'b0, 32'h0, 5'd4, 32'hAB000000, 32'h000000CD, 1'b0, 1'b0, dc);
        repeat (3) @(negedge clk);
        check("wrap_p1_addr", log_q[1].addr, 32'h0);
        drain();
        check("wrap_rdata", last_rdata, 32'h0000CDAB);

        send(32'h201, 2'd2, 1'b0, 1'b0, 32'h0, 5'd5, 32'h12345678, 32'h0, 1'b1, 1'b0, dc);
        drain();
        check("e0_err", last_err, 1);
        send(32'h300, 2'd2, 1'b0, 1'b0, 32'h0, 5'd6, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, dc);
        drain();
        check("e0_next_rdata", last_rdata, 32'hCAFEF00D);
`else
        send(32'h001, 2'd2, 1'b0, 1'b0, 32'h0, 5'd7, 32'h0, 32'h0, 1'b0, 1'b0, dc);
        drain();
        check("nm_latency", last_cyc, dc + 1);
        check("nm_err_mis", {last_err, last_mis}, 2'b11);
        check("nm_rdata", last_rdata, 0);
        check("nm_tag", last_tag, 5'd7);
`endif

        set_mode(2, 1'b1);
        fork
            send(32'h204, 2'd2, 1'b0, 1'b0, 32'h0, 5'd8, 32'h0BADCAFE, 32'h0, 1'b0, 1'b0, dc);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("dly_req", data_req_o, 1);
                    check("dly_addr", data_addr_o, 32'h204);
                    check("dly_done", lsu_req_done_o, 0);
                end
                gnt_mode = 1;
            end
        join
        drain();
        check("dly_rdata", last_rdata, 32'h0BADCAFE);

        rv_hold = 1'b1;
        send(32'h400, 2'd2, 1'b0, 1'b0, 32'h0, 5'd9, 32'h55555555, 32'h0, 1'b0, 1'b0, dc);
        rst_ni = 1'b0;
        exp_bus.delete(); exp_resp.delete(); resp_cycles.delete();
        repeat (2) begin
            @(negedge clk);
            check("arst_resp_valid", resp_valid_o, 0);
            check("arst_resp_tag", resp_tag_o, 0);
            check("arst_resp_rdata", resp_rdata_o, 0);
            check("arst_data_req", data_req_o, 0);
        end
        @(posedge clk);
        #1;
        rst_ni  = 1'b1;
        rv_hold = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        send(32'h500, 2'd1, 1'b0, 1'b1, 32'h0, 5'd10, 32'h0000_8001, 32'h0, 1'b0, 1'b0, dc);
        drain();
        check("post_rst_rdata", last_rdata, 32'hFFFF8001);

        set_mode(0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            send(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, TagW'($urandom), $urandom, $urandom,
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0), dc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (errors=%0d)", errors);
        $fatal(1);
    end

endmodule
